// File: rtl/bomber_pkg.sv
// ---------------------------------------------------------------------------
// bomber_pkg
//   Shared types and default constants for the bomber life controller.
//   - life_state_t : game state of the bomber life FSM
//   - DEF_*        : default lives / frame-count parameter values
//   - max_int      : helper used to size the frame counters
// ---------------------------------------------------------------------------
package bomber_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    INVINCIBLE = 2'd2,
    GAME_OVER  = 2'd3
  } life_state_t;

  localparam int DEF_INIT_LIVES   = 3;
  localparam int DEF_LIVES_W      = 3;
  localparam int DEF_INV_FRAMES   = 90;
  localparam int DEF_BLINK_FRAMES = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_sticky_flag.sv
// ---------------------------------------------------------------------------
// frame_sticky_flag
//   Remembers whether an input was seen at any point during the current
//   video frame. The effective flag includes the current input, so a hit in
//   the clear cycle itself still counts toward the frame being closed.
// Ports
//   clk      in  1  system clock
//   reset    in  1  synchronous, active-high reset
//   set      in  1  raw event input, OR-accumulated every cycle
//   clear    in  1  end-of-frame (or restart) clear
//   flag_eff out 1  accumulated flag OR current input
// ---------------------------------------------------------------------------
module frame_sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic flag_eff
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    flag_eff = flag_q | set;
    flag_d   = clear ? 1'b0 : (flag_q | set);
  end

  always_ff @(posedge clk) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

endmodule

// File: rtl/bomber_life_ctrl.sv
// ---------------------------------------------------------------------------
// bomber_life_ctrl
//   Turns per-pixel bomber collision flags into game state. Collisions are
//   accumulated over a video frame and evaluated once at startOfFrame; all
//   effects appear on the registered outputs one cycle later.
// Ports
//   clk                          in   1        system clock
//   reset                        in   1        synchronous, active-high reset
//   startOfFrame                 in   1        one-cycle pulse per video frame
//   game_start                   in   1        one-cycle start/restart pulse
//   collission_bomber_wall       in   1        bomber overlaps wall
//   collission_bomber_mine       in   1        bomber overlaps enemy
//   collission_bomber_explosion  in   1        bomber overlaps explosion
//   lives                        out  LIVES_W  remaining lives
//   bomber_hit                   out  1        one-cycle pulse when a life is lost
//   wall_block                   out  1        wall touched during previous frame
//   invincible                   out  1        invincibility window active
//   bomber_visible               out  1        drawing enable (blinks when invincible)
//   game_over                    out  1        game over state
// ---------------------------------------------------------------------------
module bomber_life_ctrl
  import bomber_pkg::*;
#(
  parameter int INIT_LIVES   = DEF_INIT_LIVES,
  parameter int LIVES_W      = DEF_LIVES_W,
  parameter int INV_FRAMES   = DEF_INV_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               game_start,
  input  logic               collission_bomber_wall,
  input  logic               collission_bomber_mine,
  input  logic               collission_bomber_explosion,
  output logic [LIVES_W-1:0] lives,
  output logic               bomber_hit,
  output logic               wall_block,
  output logic               invincible,
  output logic               bomber_visible,
  output logic               game_over
);

  localparam int CNT_W = $clog2(max_int(INV_FRAMES, BLINK_FRAMES) + 1);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0]   INV_LAST   = CNT_W'(INV_FRAMES - 1);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  life_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               hit_q, hit_d;
  logic               wall_block_q, wall_block_d;
  logic               visible_q, visible_d;
  logic               invincible_q, invincible_d;
  logic               game_over_q, game_over_d;

  logic wall_eff;
  logic dmg_eff;
  logic flag_clear;

  // A restart also wipes anything accumulated in the current frame.
  assign flag_clear = startOfFrame | game_start;

  frame_sticky_flag u_wall_flag (
    .clk      (clk),
    .reset    (reset),
    .set      (collission_bomber_wall),
    .clear    (flag_clear),
    .flag_eff (wall_eff)
  );

  // Mine and explosion share one flag so both in a frame cost one life.
  frame_sticky_flag u_dmg_flag (
    .clk      (clk),
    .reset    (reset),
    .set      (collission_bomber_mine | collission_bomber_explosion),
    .clear    (flag_clear),
    .flag_eff (dmg_eff)
  );

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    inv_cnt_d    = inv_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    hit_d        = 1'b0;
    wall_block_d = wall_block_q;
    visible_d    = visible_q;

    if (game_start) begin
      // Restart wins over any damage evaluation in the same cycle.
      state_d      = PLAY;
      lives_d      = LIVES_INIT;
      inv_cnt_d    = '0;
      blink_cnt_d  = '0;
      wall_block_d = 1'b0;
      visible_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          wall_block_d = 1'b0;
          visible_d    = 1'b1;
        end
        PLAY: begin
          if (startOfFrame) begin
            wall_block_d = wall_eff;
            if (dmg_eff) begin
              if (lives_q != '0) begin
                lives_d = lives_q - LIVES_W'(1);
                hit_d   = 1'b1;
              end
              if (lives_q <= LIVES_W'(1)) begin
                state_d = GAME_OVER;
              end else begin
                state_d     = INVINCIBLE;
                inv_cnt_d   = INV_LAST;
                blink_cnt_d = '0;
              end
            end
          end
        end
        INVINCIBLE: begin
          if (startOfFrame) begin
            wall_block_d = wall_eff;
            if (inv_cnt_q == '0) begin
              state_d     = PLAY;
              blink_cnt_d = '0;
              visible_d   = 1'b1;
            end else begin
              inv_cnt_d = inv_cnt_q - CNT_W'(1);
              if (blink_cnt_q >= BLINK_LAST) begin
                blink_cnt_d = '0;
                visible_d   = ~visible_q;
              end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        GAME_OVER: begin
          wall_block_d = 1'b0;
          lives_d      = '0;
          visible_d    = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Status outputs track the state being entered so they stay registered.
    invincible_d = (state_d == INVINCIBLE);
    game_over_d  = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lives_q      <= LIVES_INIT;
      inv_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      hit_q        <= 1'b0;
      wall_block_q <= 1'b0;
      visible_q    <= 1'b1;
      invincible_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      inv_cnt_q    <= inv_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      hit_q        <= hit_d;
      wall_block_q <= wall_block_d;
      visible_q    <= visible_d;
      invincible_q <= invincible_d;
      game_over_q  <= game_over_d;
    end
  end

  assign lives          = lives_q;
  assign bomber_hit     = hit_q;
  assign wall_block     = wall_block_q;
  assign invincible     = invincible_q;
  assign bomber_visible = visible_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_bomber_life_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bomber_life_ctrl
//   Directed self-checking bench for bomber_life_ctrl with default
//   parameters (3 lives, 90 invincible frames, 8-frame blink half-period).
//   A frame is four clock cycles with startOfFrame in the last one.
// ---------------------------------------------------------------------------
module tb_bomber_life_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       game_start = 1'b0;
  logic       wall = 1'b0;
  logic       mine = 1'b0;
  logic       explosion = 1'b0;
  logic [2:0] lives;
  logic       bomber_hit;
  logic       wall_block;
  logic       invincible;
  logic       bomber_visible;
  logic       game_over;

  int tests_run = 0;
  int tests_failed = 0;
  int hit_cycles = 0;

  bomber_life_ctrl dut (
    .clk                         (clk),
    .reset                       (reset),
    .startOfFrame                (startOfFrame),
    .game_start                  (game_start),
    .collission_bomber_wall      (wall),
    .collission_bomber_mine      (mine),
    .collission_bomber_explosion (explosion),
    .lives                       (lives),
    .bomber_hit                  (bomber_hit),
    .wall_block                  (wall_block),
    .invincible                  (invincible),
    .bomber_visible              (bomber_visible),
    .game_over                   (game_over)
  );

  always #5 clk = ~clk;

  // Counts cycles with bomber_hit high, sampled mid-cycle.
  always @(negedge clk) begin
    if (bomber_hit === 1'b1) hit_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic frame();
    tick();
    tick();
    tick();
    sof_tick();
  endtask

  task automatic take_hit();
    mine = 1'b1;
    tick();
    mine = 1'b0;
    tick();
    tick();
    sof_tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (lives !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL reset_lives: got %0d, expected 3", lives);
    end
    tests_run++;
    if ({bomber_hit, wall_block, invincible, bomber_visible, game_over} !== 5'b00010) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b, expected 00010",
               {bomber_hit, wall_block, invincible, bomber_visible, game_over});
    end
    take_hit();
    tests_run++;
    if (lives !== 3'd3 || invincible !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ignores_damage: lives %0d inv %b, expected 3 0", lives, invincible);
    end
  endtask

  task automatic test_play_quiet();
    int h0;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    tests_run++;
    if (lives !== 3'd3 || game_over !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL start_lives: lives %0d go %b, expected 3 0", lives, game_over);
    end
    h0 = hit_cycles;
    for (int i = 0; i < 10; i++) frame();
    tests_run++;
    if (lives !== 3'd3 || invincible !== 1'b0 || (hit_cycles - h0) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL quiet_frames: lives %0d inv %b hits %0d, expected 3 0 0",
               lives, invincible, hit_cycles - h0);
    end
  endtask

  task automatic test_hit_and_blink();
    int  h0;
    logic exp_vis;
    h0 = hit_cycles;
    take_hit();
    tests_run++;
    if (lives !== 3'd2 || bomber_hit !== 1'b1 || invincible !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_hit: lives %0d hit %b inv %b, expected 2 1 1",
               lives, bomber_hit, invincible);
    end
    tick();
    tests_run++;
    if (bomber_hit !== 1'b0 || (hit_cycles - h0) !== 1) begin
      tests_failed++;
      $display("[TB] FAIL hit_pulse_width: hit %b cycles %0d, expected 0 1",
               bomber_hit, hit_cycles - h0);
    end
    for (int k = 1; k <= 89; k++) begin
      frame();
      exp_vis = ((k / 8) % 2) == 0;
      tests_run++;
      if (invincible !== 1'b1 || bomber_visible !== exp_vis) begin
        tests_failed++;
        $display("[TB] FAIL blink_frame_%0d: inv %b vis %b, expected 1 %b",
                 k, invincible, bomber_visible, exp_vis);
      end
    end
    frame();
    tests_run++;
    if (invincible !== 1'b0 || bomber_visible !== 1'b1 || lives !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL inv_window_end: inv %b vis %b lives %0d, expected 0 1 2",
               invincible, bomber_visible, lives);
    end
  endtask

  task automatic test_double_damage();
    int h0;
    h0 = hit_cycles;
    mine = 1'b1;
    tick();
    mine = 1'b0;
    explosion = 1'b1;
    tick();
    explosion = 1'b0;
    tick();
    mine = 1'b1;
    explosion = 1'b1;
    sof_tick();
    mine = 1'b0;
    explosion = 1'b0;
    tests_run++;
    if (lives !== 3'd1 || invincible !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mine_plus_explosion: lives %0d inv %b, expected 1 1", lives, invincible);
    end
    for (int k = 1; k <= 90; k++) begin
      explosion = (k >= 5 && k <= 20);
      frame();
    end
    explosion = 1'b0;
    tests_run++;
    if (lives !== 3'd1 || invincible !== 1'b0 || (hit_cycles - h0) !== 1) begin
      tests_failed++;
      $display("[TB] FAIL inv_discards_damage: lives %0d inv %b hits %0d, expected 1 0 1",
               lives, invincible, hit_cycles - h0);
    end
  endtask

  task automatic test_game_over();
    int h0;
    take_hit();
    tests_run++;
    if (lives !== 3'd0 || game_over !== 1'b1 || bomber_hit !== 1'b1 || invincible !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL last_life: lives %0d go %b hit %b inv %b, expected 0 1 1 0",
               lives, game_over, bomber_hit, invincible);
    end
    tick();
    h0 = hit_cycles;
    take_hit();
    tick();
    tests_run++;
    if (lives !== 3'd0 || game_over !== 1'b1 || (hit_cycles - h0) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL no_underflow: lives %0d go %b hits %0d, expected 0 1 0",
               lives, game_over, hit_cycles - h0);
    end
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    tests_run++;
    if (lives !== 3'd3 || game_over !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_from_over: lives %0d go %b, expected 3 0", lives, game_over);
    end
    for (int h = 0; h < 3; h++) begin
      take_hit();
      tests_run++;
      if (lives !== 3'(2 - h)) begin
        tests_failed++;
        $display("[TB] FAIL three_hits_%0d: lives %0d, expected %0d", h, lives, 2 - h);
      end
      if (h < 2) begin
        for (int k = 0; k < 90; k++) frame();
      end
    end
    tests_run++;
    if (game_over !== 1'b1 || lives !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL three_hits_over: go %b lives %0d, expected 1 0", game_over, lives);
    end
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    tests_run++;
    if (lives !== 3'd3 || game_over !== 1'b0 || invincible !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL second_restart: lives %0d go %b inv %b, expected 3 0 0",
               lives, game_over, invincible);
    end
  endtask

  task automatic test_wall();
    wall = 1'b1;
    sof_tick();
    wall = 1'b0;
    tests_run++;
    if (wall_block !== 1'b1 || lives !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL wall_in_sof: wb %b lives %0d, expected 1 3", wall_block, lives);
    end
    tick();
    tests_run++;
    if (wall_block !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wall_held: wb %b, expected 1", wall_block);
    end
    tick();
    tick();
    sof_tick();
    tests_run++;
    if (wall_block !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wall_one_frame: wb %b, expected 0", wall_block);
    end
    wall = 1'b1;
    tick();
    wall = 1'b0;
    tick();
    tick();
    sof_tick();
    tests_run++;
    if (wall_block !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wall_mid_frame: wb %b, expected 1", wall_block);
    end
    frame();
    tests_run++;
    if (wall_block !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wall_clears: wb %b, expected 0", wall_block);
    end
  endtask

  task automatic test_restart_priority();
    int h0;
    h0 = hit_cycles;
    mine = 1'b1;
    tick();
    mine = 1'b0;
    tick();
    tick();
    startOfFrame = 1'b1;
    game_start = 1'b1;
    tick();
    startOfFrame = 1'b0;
    game_start = 1'b0;
    tests_run++;
    if (lives !== 3'd3 || bomber_hit !== 1'b0 || invincible !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL start_beats_damage: lives %0d hit %b inv %b, expected 3 0 0",
               lives, bomber_hit, invincible);
    end
    frame();
    tests_run++;
    if (lives !== 3'd3 || (hit_cycles - h0) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL start_clears_flags: lives %0d hits %0d, expected 3 0",
               lives, hit_cycles - h0);
    end
  endtask

  task automatic test_reset_mid();
    int h0;
    take_hit();
    frame();
    frame();
    frame();
    reset = 1'b1;
    mine = 1'b1;
    game_start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mine = 1'b0;
    game_start = 1'b0;
    tests_run++;
    if (lives !== 3'd3 || invincible !== 1'b0 || bomber_visible !== 1'b1 ||
        game_over !== 1'b0 || bomber_hit !== 1'b0 || wall_block !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_inv: lives %0d inv %b vis %b go %b hit %b wb %b, expected 3 0 1 0 0 0",
               lives, invincible, bomber_visible, game_over, bomber_hit, wall_block);
    end
    h0 = hit_cycles;
    take_hit();
    tick();
    tests_run++;
    if (lives !== 3'd3 || invincible !== 1'b0 || (hit_cycles - h0) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: lives %0d inv %b hits %0d, expected 3 0 0",
               lives, invincible, hit_cycles - h0);
    end
  endtask

  initial begin
    test_reset();
    test_play_quiet();
    test_hit_and_blink();
    test_double_damage();
    test_game_over();
    test_wall();
    test_restart_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
